pixel_frame_receiver: RTL and testbench
=======================================

// Module: pixel_frame_receiver
// PURPOSE
//   Receiving end of the SENSOR_TOP pixel readout stream. Takes digitized pixels as the sensor
//   reads them out, checks frame framing against the array geometry, and tags each pixel with
//   start-of-frame, end-of-line and end-of-frame sideband bits. Buffers the tagged pixels in a
//   small FIFO and presents them downstream over a valid/ready handshake.
//   Sensor readout cannot stall, so the block detects overflow and recovers on the next frame.
// PARAMETERS
//   PIXEL_ARRAY_WIDTH   3  pixels per row (>=1)
//   PIXEL_ARRAY_HEIGHT  3  rows per frame (>=1)
//   DATA_WIDTH          8  bits per pixel word
//   FIFO_DEPTH          4  FIFO entries, power of two, >=2
// PORTS
//   clk          in   1           single clock; all logic on rising edge
//   reset        in   1           synchronous, active-low reset
//   in_valid     in   1           pixel present on in_data this cycle (no back-pressure)
//   in_sof       in   1           first pixel of a frame; qualified by in_valid
//   in_data      in   DATA_WIDTH  pixel value
//   out_valid    out  1           FIFO head valid
//   out_ready    in   1           downstream accepts head when out_valid&&out_ready
//   out_data     out  DATA_WIDTH  head pixel value
//   out_sof      out  1           head is pixel (row 0, col 0)
//   out_eol      out  1           head is last pixel of a row
//   out_eof      out  1           head is last pixel of the frame
//   frame_count  out  16          completed frames pushed to FIFO; wraps 0xFFFF->0
//   overflow     out  1           sticky: pixel dropped because FIFO full
//   frame_error  out  1           sticky: in_sof arrived mid-frame
//   busy         out  1           state!=IDLE or FIFO non-empty
// BEHAVIOUR
//   Reset (reset==0 at clk edge): FIFO emptied, state IDLE, row/col=0, all outputs 0.
//     Reset mid-frame discards partial frame and buffered data.
//   FIFO entry = {eof,eol,sof,data}. Push condition: count<FIFO_DEPTH, or count==FIFO_DEPTH
//     with a pop in the same cycle. Simultaneous push+pop leaves count unchanged.
//   Latency: pixel accepted in cycle N into an empty FIFO drives out_valid/out_data in N+1.
//   out_* held stable while out_valid && !out_ready. out_valid = (count!=0).
//   State machine:
//   IDLE: in_valid&&!in_sof ignored. in_valid&&in_sof -> push pixel with sof=1 as (0,0),
//     go RECEIVE (or stay IDLE if 1x1 frame, which completes at once).
//   RECEIVE: each in_valid pushes a pixel. col increments; at col==W-1 set eol, col->0, row++.
//     Pixel at (H-1,W-1) also sets eof; frame_count++ on its push; row/col->0; go IDLE.
//     in_valid&&in_sof -> frame_error=1, abandon partial frame, restart as new frame at (0,0)
//     with sof=1 (pixels of the partial frame already in FIFO are still delivered).
//   DROP: entered when a push is refused (FIFO full); overflow=1, pixel discarded, frame not
//     counted. All pixels discarded until in_valid&&in_sof, handled exactly as in IDLE.
//   W==1: every pixel has eol=1. 1x1: single pixel carries sof, eol, eof together.
//   frame_error/overflow clear only on reset.
// TESTING
//   1) reset low 2 cycles; 3x3 frame 0x10..0x18, out_ready=1 -> same sequence out, 1-cycle
//      latency, sof on 0x10, eol on 0x12/0x15/0x18, eof on 0x18, frame_count=1.
//   2) out_ready=0, 9-pixel frame, FIFO_DEPTH=4 -> 0x10..0x13 buffered, 0x14 dropped,
//      overflow=1, frame_count=0; raise out_ready -> 4 words drain; next frame counted (=1).
//   3) in_sof with 5th pixel of a frame -> frame_error=1, that pixel out with sof=1,
//      following 8 pixels complete frame, frame_count=1.
//   4) in_valid with in_sof=0 while IDLE -> no push, out_valid stays 0, busy=0.
//   5) FIFO full, out_ready=1 every cycle with in_valid each cycle -> no overflow, data in order;
//      out_ready toggled 1/0 -> out_data stable in stall cycles.
//   6) reset low after 4 pixels -> next cycle out_valid=0, frame_count=0, busy=0;
//      a following full frame delivered normally.

Source files
------------

// File: rtl/pixel_frame_receiver.sv
// Receives a non-stallable pixel stream, tags frame position (sof/eol/eof), buffers tagged
// pixels in a small FIFO and hands them downstream over valid/ready.
module pixel_frame_receiver #(
    parameter int unsigned PIXEL_ARRAY_WIDTH  = 3,
    parameter int unsigned PIXEL_ARRAY_HEIGHT = 3,
    parameter int unsigned DATA_WIDTH         = 8,
    parameter int unsigned FIFO_DEPTH         = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  in_sof,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sof,
    output logic                  out_eol,
    output logic                  out_eof,
    output logic [15:0]           frame_count,
    output logic                  overflow,
    output logic                  frame_error,
    output logic                  busy
);

    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CountW = PtrW + 1;
    localparam int unsigned ColW   = (PIXEL_ARRAY_WIDTH > 1) ? $clog2(PIXEL_ARRAY_WIDTH) : 1;
    localparam int unsigned RowW   = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;
    localparam int unsigned EntryW = DATA_WIDTH + 3;

    typedef enum logic [1:0] {StIdle, StReceive, StDrop} state_e;

    state_e state_q, state_d;

    logic [EntryW-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CountW-1:0] count_q;
    logic [ColW-1:0]   col_q, cur_col;
    logic [RowW-1:0]   row_q, cur_row;
    logic [15:0]       frame_count_q;
    logic              overflow_q, frame_error_q;

    logic pop, can_push, start, take, push, refuse, mid_sof;
    logic pix_eol, pix_eof;

    // Pixel decode: a start-of-frame always restarts at (0,0) regardless of state.
    always_comb begin
        pop      = (count_q != '0) && out_ready;
        can_push = (count_q != CountW'(FIFO_DEPTH)) || pop;
        start    = in_valid && in_sof;
        take     = start || (in_valid && (state_q == StReceive));
        mid_sof  = start && (state_q == StReceive);
        cur_col  = start ? '0 : col_q;
        cur_row  = start ? '0 : row_q;
        pix_eol  = (cur_col == ColW'(PIXEL_ARRAY_WIDTH - 1));
        pix_eof  = pix_eol && (cur_row == RowW'(PIXEL_ARRAY_HEIGHT - 1));
        push     = take && can_push;
        refuse   = take && !can_push;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Idle and drop both wait for a start pixel; take is only set by one in those states.
    always_comb begin
        state_d = state_q;
        if (refuse) begin
            state_d = StDrop;
        end else if (push) begin
            state_d = pix_eof ? StIdle : StReceive;
        end
    end

    always_comb begin
        out_valid   = (count_q != '0);
        {out_eof, out_eol, out_sof, out_data} = out_valid ? mem_q[rd_ptr_q] : '0;
        busy        = (state_q != StIdle) || out_valid;
        frame_count = frame_count_q;
        overflow    = overflow_q;
        frame_error = frame_error_q;
    end

    // Storage needs no reset: the head is masked until count_q says it is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {pix_eof, pix_eol, start, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            col_q         <= '0;
            row_q         <= '0;
            frame_count_q <= '0;
            overflow_q    <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CountW'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CountW'(1);
            end

            if (push) begin
                if (pix_eol) begin
                    col_q <= '0;
                    row_q <= pix_eof ? '0 : cur_row + RowW'(1);
                end else begin
                    col_q <= cur_col + ColW'(1);
                    row_q <= cur_row;
                end
            end else if (refuse) begin
                col_q <= '0;
                row_q <= '0;
            end

            if (push && pix_eof) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
            if (refuse) begin
                overflow_q <= 1'b1;
            end
            if (mid_sof) begin
                frame_error_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_frame_receiver.sv
// Self-checking bench for pixel_frame_receiver: directed scenarios plus a randomized run,
// all checked against a queue-based frame model.
module tb_pixel_frame_receiver;

    localparam int W  = 3;
    localparam int H  = 3;
    localparam int DW = 8;
    localparam int D  = 4;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_sof;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_sof;
    logic          out_eol;
    logic          out_eof;
    logic [15:0]   frame_count;
    logic          overflow;
    logic          frame_error;
    logic          busy;

    int n_pass  = 0;
    int n_total = 0;

    // Model: queue of tagged words {eof,eol,sof,data}, plus pixel index within the frame.
    logic [DW+2:0] mq[$];
    logic [DW+2:0] dump;
    int            idx;
    bit            in_frame;
    bit            dropping;
    logic [15:0]   m_fc;
    bit            m_ovf;
    bit            m_err;

    pixel_frame_receiver #(
        .PIXEL_ARRAY_WIDTH (W),
        .PIXEL_ARRAY_HEIGHT(H),
        .DATA_WIDTH        (DW),
        .FIFO_DEPTH        (D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sof    (out_sof),
        .out_eol    (out_eol),
        .out_eof    (out_eof),
        .frame_count(frame_count),
        .overflow   (overflow),
        .frame_error(frame_error),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input logic rst_n, input logic v, input logic s,
                        input logic [DW-1:0] d, input logic rdy);
        bit take;
        bit eol;
        bit eof;
        reset     = rst_n;
        in_valid  = v;
        in_sof    = s;
        in_data   = d;
        out_ready = rdy;
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            idx = 0; in_frame = 0; dropping = 0; m_fc = '0; m_ovf = 0; m_err = 0;
        end else begin
            if (rdy && mq.size() > 0) dump = mq.pop_front();
            if (v) begin
                take = 0;
                if (s) begin
                    if (in_frame) m_err = 1;
                    idx  = 0;
                    take = 1;
                end else if (in_frame) begin
                    take = 1;
                end
                if (take) begin
                    eol = ((idx % W) == W - 1);
                    eof = eol && ((idx / W) == H - 1);
                    if (mq.size() < D) begin
                        mq.push_back({eof, eol, (idx == 0), d});
                        dropping = 0;
                        if (eof) begin
                            m_fc++;
                            in_frame = 0;
                            idx = 0;
                        end else begin
                            in_frame = 1;
                            idx++;
                        end
                    end else begin
                        m_ovf = 1; in_frame = 0; dropping = 1; idx = 0;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        tick(0, 0, 0, '0, 0);
        tick(0, 0, 0, '0, 0);
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", out_valid);
        else n_pass++;
        n_total++; if (frame_count !== 16'd0) $display("FAIL reset_fc: got %0d want 0", frame_count);
        else n_pass++;
        n_total++;
        if ({overflow, frame_error, busy} !== 3'b000)
            $display("FAIL reset_flags: got %b want 000", {overflow, frame_error, busy});
        else n_pass++;
    endtask

    task automatic test_basic_frame();
        logic [DW+2:0] exp;
        for (int i = 0; i < 9; i++) begin
            tick(1, 1, (i == 0), 8'(16 + i), 1);
            exp = {(i == 8), (i % 3 == 2), (i == 0), 8'(16 + i)};
            n_total++;
            if (out_valid !== 1'b1 || {out_eof, out_eol, out_sof, out_data} !== exp)
                $display("FAIL basic_word%0d: got v=%0b %h want v=1 %h", i, out_valid,
                         {out_eof, out_eol, out_sof, out_data}, exp);
            else n_pass++;
        end
        tick(1, 0, 0, '0, 1);
        n_total++; if (frame_count !== 16'd1) $display("FAIL basic_fc: got %0d want 1", frame_count);
        else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL basic_empty: got %0b want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_overflow();
        tick(0, 0, 0, '0, 0);
        for (int i = 0; i < 9; i++) tick(1, 1, (i == 0), 8'(16 + i), 0);
        n_total++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %0b want 1", overflow);
        else n_pass++;
        n_total++; if (frame_count !== 16'd0) $display("FAIL ovf_fc: got %0d want 0", frame_count);
        else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL ovf_busy: got %0b want 1", busy);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if (out_valid !== 1'b1 || out_data !== 8'(16 + k))
                $display("FAIL ovf_drain%0d: got v=%0b %h want v=1 %h", k, out_valid, out_data,
                         8'(16 + k));
            else n_pass++;
            tick(1, 0, 0, '0, 1);
        end
        n_total++; if (out_valid !== 1'b0) $display("FAIL ovf_drained: got %0b want 0", out_valid);
        else n_pass++;
        for (int i = 0; i < 9; i++) tick(1, 1, (i == 0), 8'(48 + i), 1);
        tick(1, 0, 0, '0, 1);
        n_total++; if (frame_count !== 16'd1) $display("FAIL ovf_next_fc: got %0d want 1", frame_count);
        else n_pass++;
        n_total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %0b want 1", overflow);
        else n_pass++;
    endtask

    task automatic test_frame_error();
        tick(0, 0, 0, '0, 0);
        for (int i = 0; i < 4; i++) tick(1, 1, (i == 0), 8'(32 + i), 1);
        n_total++; if (frame_error !== 1'b0) $display("FAIL ferr_early: got %0b want 0", frame_error);
        else n_pass++;
        tick(1, 1, 1, 8'h24, 1);
        n_total++;
        if (frame_error !== 1'b1 || out_sof !== 1'b1 || out_data !== 8'h24)
            $display("FAIL ferr_restart: got err=%0b sof=%0b %h want err=1 sof=1 24",
                     frame_error, out_sof, out_data);
        else n_pass++;
        for (int i = 0; i < 8; i++) tick(1, 1, 0, 8'(37 + i), 1);
        n_total++; if (out_eof !== 1'b1 || out_data !== 8'h2c)
            $display("FAIL ferr_eof: got eof=%0b %h want eof=1 2c", out_eof, out_data);
        else n_pass++;
        tick(1, 0, 0, '0, 1);
        n_total++; if (frame_count !== 16'd1) $display("FAIL ferr_fc: got %0d want 1", frame_count);
        else n_pass++;
    endtask

    task automatic test_idle_ignore();
        tick(0, 0, 0, '0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(1, 1, 0, 8'(80 + i), 1);
            n_total++;
            if (out_valid !== 1'b0 || busy !== 1'b0)
                $display("FAIL idle_ignore%0d: got v=%0b busy=%0b want 0 0", i, out_valid, busy);
            else n_pass++;
        end
    endtask

    task automatic test_full_throughput();
        logic [DW-1:0] prev;
        tick(0, 0, 0, '0, 0);
        for (int i = 0; i < 4; i++) tick(1, 1, (i == 0), 8'(64 + i), 0);
        for (int i = 4; i < 9; i++) begin
            tick(1, 1, 0, 8'(64 + i), 1);
            n_total++;
            if (overflow !== 1'b0 || out_valid !== 1'b1 || out_data !== mq[0][DW-1:0])
                $display("FAIL full_tp%0d: got ovf=%0b v=%0b %h want 0 1 %h", i, overflow,
                         out_valid, out_data, mq[0][DW-1:0]);
            else n_pass++;
        end
        n_total++; if (frame_count !== 16'd1) $display("FAIL full_fc: got %0d want 1", frame_count);
        else n_pass++;
        for (int j = 0; j < 8; j++) begin
            prev = out_data;
            tick(1, 0, 0, '0, (j % 2 == 1));
            if (j % 2 == 0) begin
                n_total++;
                if (out_valid !== 1'b1 || out_data !== prev)
                    $display("FAIL stall_stable%0d: got v=%0b %h want v=1 %h", j, out_valid,
                             out_data, prev);
                else n_pass++;
            end else if (mq.size() > 0) begin
                n_total++;
                if (out_data !== mq[0][DW-1:0])
                    $display("FAIL stall_order%0d: got %h want %h", j, out_data, mq[0][DW-1:0]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 4; i++) tick(1, 1, (i == 0), 8'(96 + i), 0);
        tick(0, 0, 0, '0, 0);
        n_total++;
        if ({out_valid, busy} !== 2'b00 || frame_count !== 16'd0)
            $display("FAIL midrst: got v=%0b busy=%0b fc=%0d want 0 0 0", out_valid, busy,
                     frame_count);
        else n_pass++;
        for (int i = 0; i < 9; i++) begin
            tick(1, 1, (i == 0), 8'(112 + i), 1);
            n_total++;
            if (out_data !== 8'(112 + i))
                $display("FAIL midrst_word%0d: got %h want %h", i, out_data, 8'(112 + i));
            else n_pass++;
        end
        tick(1, 0, 0, '0, 1);
        n_total++; if (frame_count !== 16'd1) $display("FAIL midrst_fc: got %0d want 1", frame_count);
        else n_pass++;
    endtask

    task automatic test_random();
        logic          v, s, r, rst_n;
        logic [DW+2:0] got;
        tick(0, 0, 0, '0, 0);
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(499, 0) != 0);
            v     = ($urandom_range(9, 0) < 7);
            s     = v && ($urandom_range(9, 0) == 0);
            r     = ($urandom_range(9, 0) < 6);
            tick(rst_n, v, s, 8'($urandom), r);
            got = {out_eof, out_eol, out_sof, out_data};
            n_total++;
            if (out_valid !== (mq.size() != 0) || (mq.size() != 0 && got !== mq[0]))
                $display("FAIL rand_head c=%0d: got v=%0b %h want v=%0b %h", c, out_valid, got,
                         (mq.size() != 0), (mq.size() != 0) ? mq[0] : '0);
            else n_pass++;
            n_total++;
            if (frame_count !== m_fc || overflow !== m_ovf || frame_error !== m_err ||
                busy !== (in_frame || dropping || mq.size() != 0))
                $display("FAIL rand_status c=%0d: got fc=%0d ovf=%0b err=%0b busy=%0b want %0d %0b %0b %0b",
                         c, frame_count, overflow, frame_error, busy, m_fc, m_ovf, m_err,
                         (in_frame || dropping || mq.size() != 0));
            else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; out_ready = 1'b0;
        test_reset();
        test_basic_frame();
        test_overflow();
        test_frame_error();
        test_idle_ignore();
        test_full_throughput();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
